// File: rtl/pwm_peripheral.sv
// pwm_peripheral
//   Turns the SPI-written control registers into 16 output pins. Each pin is
//   forced low, driven high, or driven with one shared 8-bit PWM waveform.
//   The requested duty cycle is shadowed and only takes effect at a period
//   boundary, so a register write can never produce a runt pulse.
//
// Ports
//   clk              system clock (same domain as the SPI register file)
//   rst              synchronous, active-high reset
//   en_reg_out_7_0   output enable, pins 7..0
//   en_reg_out_15_8  output enable, pins 15..8
//   en_reg_pwm_7_0   PWM mode select, pins 7..0
//   en_reg_pwm_15_8  PWM mode select, pins 15..8
//   pwm_duty_cycle   requested duty cycle, 0x00..0xFF
//   pwm_out          registered output pins, bit i = pin i
//   period_start     one-clk pulse while the first count (0x00) of a period is live
module pwm_peripheral #(
   parameter int PRESCALE = 12,
   parameter int NUM_PINS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          en_reg_out_7_0,
   input  logic [7:0]          en_reg_out_15_8,
   input  logic [7:0]          en_reg_pwm_7_0,
   input  logic [7:0]          en_reg_pwm_15_8,
   input  logic [7:0]          pwm_duty_cycle,
   output logic [NUM_PINS-1:0] pwm_out,
   output logic                period_start
);

   // A one-bit counter is kept even for PRESCALE=1; it then sits at 0 and
   // tick is asserted every cycle.
   localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0]     prescale_cnt;
   logic [7:0]          pwm_cnt;
   logic [7:0]          duty_active;
   logic                tick;
   logic                wrap;
   logic                pwm_lvl;
   logic [NUM_PINS-1:0] en_out;
   logic [NUM_PINS-1:0] en_pwm;
   logic [NUM_PINS-1:0] pin_sel;

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   assign tick = (prescale_cnt == PS_MAX);
   // The edge on which pwm_cnt rolls 0xFF -> 0x00; the shadow loads here.
   assign wrap = tick && (pwm_cnt == 8'hFF);

   // 0xFF is a true always-high, not 255/256.
   assign pwm_lvl = (duty_active == 8'hFF) ? 1'b1 : (pwm_cnt < duty_active);

   generate
      for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
         assign pin_sel[i] = en_out[i] & (en_pwm[i] ? pwm_lvl : 1'b1);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         prescale_cnt <= '0;
         pwm_cnt      <= 8'h00;
         duty_active  <= 8'h00;
         pwm_out      <= '0;
         period_start <= 1'b0;
      end else begin
         prescale_cnt <= tick ? '0 : prescale_cnt + 1'b1;
         if (tick)
            pwm_cnt <= pwm_cnt + 8'd1;
         if (wrap)
            duty_active <= pwm_duty_cycle;
         period_start <= wrap;
         // Not gated by tick: enable changes show up one clk later.
         pwm_out      <= pin_sel;
      end
   end

endmodule

// File: tb/tb_pwm_peripheral.sv
module tb_pwm_peripheral;

   localparam int PS  = 2;
   localparam int PER = 256 * PS;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [15:0] pwm_out;
   logic        period_start;

   int n_pass  = 0;
   int n_total = 0;

   pwm_peripheral #(.PRESCALE(PS)) dut (
      .clk             (clk),
      .rst             (rst),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .pwm_out         (pwm_out),
      .period_start    (period_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] eo;
      logic [15:0] ep;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl [6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
      {en_reg_out_15_8, en_reg_out_7_0} = eo;
      {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
   endtask

   // Steps until period_start is seen; n = number of edges taken.
   task automatic wait_ps(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!period_start && n < 2000);
   endtask

   // Called right after a sample with period_start=1. Samples the whole period
   // (PER edges) on pin 0 and ends on the next period_start sample.
   task automatic run_period(input string nm, input int exp_hi, input bit exp_first,
                             input int exp_chg, input int wr_idx, input logic [7:0] wr_val);
      int hi, chg, oth, ps_mid;
      bit first, prev;
      hi = 0; chg = 0; oth = 0; ps_mid = 0; first = 1'b0; prev = 1'b0;
      for (int k = 1; k <= PER; k++) begin
         step();
         if (pwm_out[0]) hi++;
         if (k == 1) first = pwm_out[0];
         else if (pwm_out[0] != prev) chg++;
         prev = pwm_out[0];
         if (pwm_out[15:1] != 15'h0) oth++;
         if (k < PER && period_start) ps_mid++;
         if (k == wr_idx) pwm_duty_cycle = wr_val;
      end
      check({nm, " high_clks"}, hi, exp_hi);
      check({nm, " first_lvl"}, {31'd0, first}, {31'd0, exp_first});
      check({nm, " edges"}, chg, exp_chg);
      check({nm, " other_pins"}, oth, 0);
      check({nm, " ps_mid"}, ps_mid, 0);
      check({nm, " ps_end"}, {31'd0, period_start}, 32'd1);
   endtask

   initial begin
      int n, lows;

      tbl[0] = '{eo: 16'hA5F0, ep: 16'h0000, exp: 16'hA5F0};
      tbl[1] = '{eo: 16'h0000, ep: 16'h0000, exp: 16'h0000};
      tbl[2] = '{eo: 16'h0000, ep: 16'hFFFF, exp: 16'h0000};
      tbl[3] = '{eo: 16'hFFFF, ep: 16'h0F0F, exp: 16'hF0F0};
      tbl[4] = '{eo: 16'h1234, ep: 16'h0000, exp: 16'h1234};
      tbl[5] = '{eo: 16'h8001, ep: 16'h8000, exp: 16'h0001};

      // Reset held 3 clk with every input at all-ones.
      rst = 1'b1;
      set_en(16'hFFFF, 16'hFFFF);
      pwm_duty_cycle = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst pwm_out", pwm_out, 16'h0000);
         check("rst period_start", {31'd0, period_start}, 32'd0);
      end

      rst = 1'b0;
      set_en(16'h0000, 16'h0000);
      pwm_duty_cycle = 8'h80;

      // Static pin select; duty_active is 0 in the first period so PWM pins are low.
      for (int i = 0; i < 6; i++) begin
         set_en(tbl[i].eo, tbl[i].ep);
         step();
         check($sformatf("static vec%0d", i), pwm_out, tbl[i].exp);
      end

      set_en(16'h0001, 16'h0001);
      wait_ps(n);
      check("first period_start clks", n + 6, PER);

      // Duty writes mid-period only apply at the next wrap.
      run_period("duty80", 256, 1'b1, 1, 100, 8'hFF);
      run_period("dutyFF", PER, 1'b1, 0, 300, 8'h00);
      run_period("duty00", 0,   1'b0, 0, 10,  8'h01);
      run_period("duty01", PS,  1'b1, 1, 400, 8'h40);
      // 0xC0 written while pwm_cnt == 0x20 (state index 65).
      run_period("duty40", 64*PS,  1'b1, 1, 65, 8'hC0);
      run_period("dutyC0", 192*PS, 1'b1, 1, 50, 8'hFF);

      // Reset mid-period at pwm_cnt 0x90 with duty 0xFF active.
      for (int k = 0; k < 8'h90 * PS; k++) step();
      check("pre-reset pin0", {31'd0, pwm_out[0]}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst pwm_out", pwm_out, 16'h0000);
      check("midrst period_start", {31'd0, period_start}, 32'd0);
      lows = 0;
      n = 0;
      do begin
         step();
         n++;
         if (pwm_out[0] == 1'b0) lows++;
      end while (!period_start && n < 2000);
      check("post-rst period_start clks", n, PER);
      check("post-rst pin0 low clks", lows, PER);
      step();
      check("post-rst dutyFF pin0", {31'd0, pwm_out[0]}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
